// File: rtl/gnw_arb_pkg.sv
// Shared types and constants for the Game & Watch SDRAM port arbiter.
package gnw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    localparam int HDR_BYTES_DEFAULT = 13;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_OVERRUN = 1;

endpackage

// File: rtl/gnw_arb_rdcache.sv
// Single-entry LCD read cache; the tag is the header-shifted SDRAM address.
module gnw_arb_rdcache
    import gnw_arb_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [7:0]        hit_data,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [7:0]        fill_data,
    input  logic              inv_wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              inv_all
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [7:0]        data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inv_all) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (inv_wr && (wr_addr == tag)) begin
            valid <= 1'b0;
        end
    end

    assign hit      = valid && (lookup_addr == tag);
    assign hit_data = data;

endmodule

// File: rtl/gnw_sdram_arb.sv
// SDRAM port arbiter: HPS download writes vs. LCD byte reads, with header offset and backpressure.
// Optional single-entry read cache enabled by defining GNW_ARB_RDCACHE_EN.
//
// state   | meaning
// IDLE    | no command outstanding; pending write wins over a read
// WRITE   | sd_we issued, waiting for sd_ready
// READ    | sd_rd issued, waiting for sd_ready
// RECOVER | one cycle after a timeout, access abandoned
module gnw_sdram_arb
    import gnw_arb_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int HDR_BYTES = HDR_BYTES_DEFAULT,
    parameter int TIMEOUT   = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_rd,
    input  logic [7:0]        sd_dout,
    input  logic              sd_ready,
    output logic              busy,
    output logic [1:0]        err
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] HDR_OFS  = ADDR_W'(HDR_BYTES);

    arb_state_t        state, state_nxt;
    logic              pend, pend_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic [7:0]        pend_data, pend_data_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        err_nxt;
    logic              dl_active_q, dl_rise;
    logic [ADDR_W-1:0] sd_addr_nxt, rd_addr_sh, wr_addr;
    logic [7:0]        sd_din_nxt, rd_data_nxt, wr_data;
    logic              sd_we_nxt, sd_rd_nxt, rd_valid_nxt;
    logic              cache_hit, cache_fill, cache_inv_wr, cache_inv_all;
    logic [7:0]        cache_data;

    assign dl_rise    = dl_active & ~dl_active_q;
    assign rd_addr_sh = rd_addr + HDR_OFS;
    // A fresh dl_wr in IDLE is issued straight away, without waiting for the pending register.
    assign wr_addr    = pend ? pend_addr : dl_addr;
    assign wr_data    = pend ? pend_data : dl_data;
    assign dl_wait    = pend;

    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        pend_addr_nxt = pend_addr;
        pend_data_nxt = pend_data;
        cnt_nxt       = cnt;
        err_nxt       = dl_rise ? 2'b00 : err;
        sd_addr_nxt   = sd_addr;
        sd_din_nxt    = sd_din;
        sd_we_nxt     = 1'b0;
        sd_rd_nxt     = 1'b0;
        rd_valid_nxt  = 1'b0;
        rd_data_nxt   = rd_data;
        cache_fill    = 1'b0;
        cache_inv_wr  = 1'b0;
        cache_inv_all = dl_rise;

        if (dl_wr) begin
            if (pend) begin
                err_nxt[ERR_OVERRUN] = 1'b1;
            end else begin
                pend_nxt      = 1'b1;
                pend_addr_nxt = dl_addr;
                pend_data_nxt = dl_data;
            end
        end

        case (state)
            IDLE: begin
                if (pend || dl_wr) begin
                    state_nxt    = WRITE;
                    cnt_nxt      = '0;
                    sd_addr_nxt  = wr_addr;
                    sd_din_nxt   = wr_data;
                    sd_we_nxt    = 1'b1;
                    cache_inv_wr = 1'b1;
                end else if (rd_req && !dl_active && !rd_valid) begin
                    if (cache_hit) begin
                        rd_valid_nxt = 1'b1;
                        rd_data_nxt  = cache_data;
                    end else begin
                        state_nxt   = READ;
                        cnt_nxt     = '0;
                        sd_addr_nxt = rd_addr_sh;
                        sd_rd_nxt   = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (sd_ready) begin
                    pend_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    pend_nxt             = 1'b0;
                    err_nxt[ERR_TIMEOUT] = 1'b1;
                    cache_inv_all        = 1'b1;
                    state_nxt            = RECOVER;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READ: begin
                if (sd_ready) begin
                    rd_valid_nxt = 1'b1;
                    rd_data_nxt  = sd_dout;
                    cache_fill   = 1'b1;
                    state_nxt    = IDLE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt[ERR_TIMEOUT] = 1'b1;
                    cache_inv_all        = 1'b1;
                    state_nxt            = RECOVER;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend        <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            cnt         <= '0;
            err         <= 2'b00;
            dl_active_q <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_we       <= 1'b0;
            sd_rd       <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend        <= pend_nxt;
            pend_addr   <= pend_addr_nxt;
            pend_data   <= pend_data_nxt;
            cnt         <= cnt_nxt;
            err         <= err_nxt;
            dl_active_q <= dl_active;
            sd_addr     <= sd_addr_nxt;
            sd_din      <= sd_din_nxt;
            sd_we       <= sd_we_nxt;
            sd_rd       <= sd_rd_nxt;
            rd_valid    <= rd_valid_nxt;
            rd_data     <= rd_data_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

`ifdef GNW_ARB_RDCACHE_EN
    gnw_arb_rdcache #(
        .ADDR_W(ADDR_W)
    ) u_rdcache (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_addr(rd_addr_sh),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .fill       (cache_fill),
        .fill_addr  (sd_addr),
        .fill_data  (sd_dout),
        .inv_wr     (cache_inv_wr),
        .wr_addr    (wr_addr),
        .inv_all    (cache_inv_all)
    );
`else
    logic unused_cache;
    assign cache_hit    = 1'b0;
    assign cache_data   = 8'h00;
    assign unused_cache = ^{cache_fill, cache_inv_wr, cache_inv_all};
`endif

endmodule

// File: tb/tb_gnw_sdram_arb.sv
// Directed self-checking bench for gnw_sdram_arb (default build and GNW_ARB_RDCACHE_EN build).
module tb_gnw_sdram_arb;

    logic        clk;
    logic        rst_n;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic        sd_we, sd_rd;
    logic [7:0]  sd_dout;
    logic        sd_ready;
    logic        busy;
    logic [1:0]  err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_sd_rd = 0, n_sd_we = 0, n_rd_valid = 0, n_wait = 0, n_both = 0;

    gnw_sdram_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dl_active(dl_active),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .dl_data  (dl_data),
        .dl_wait  (dl_wait),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .sd_addr  (sd_addr),
        .sd_din   (sd_din),
        .sd_we    (sd_we),
        .sd_rd    (sd_rd),
        .sd_dout  (sd_dout),
        .sd_ready (sd_ready),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sd_rd) n_sd_rd++;
        if (sd_we) n_sd_we++;
        if (rd_valid) n_rd_valid++;
        if (dl_wait) n_wait++;
        if (sd_rd && sd_we) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [24:0] addr, input logic [7:0] dout,
                           input logic [24:0] exp_sd);
        int rd0;
        rd0 = n_sd_rd;
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        check({tag, " sd_rd"}, 32'(sd_rd), 32'd1);
        check({tag, " sd_addr"}, 32'(sd_addr), 32'(exp_sd));
        tick();
        check({tag, " early rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, " sd_addr held"}, 32'(sd_addr), 32'(exp_sd));
        sd_ready = 1'b1;
        sd_dout  = dout;
        tick();
        sd_ready = 1'b0;
        check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, " rd_data"}, 32'(rd_data), 32'(dout));
        rd_req = 1'b0;
        tick();
        check({tag, " rd_valid pulse"}, 32'(rd_valid), 32'd0);
        check({tag, " sd_rd count"}, 32'(n_sd_rd - rd0), 32'd1);
    endtask

    initial begin
        int base;
        rst_n = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        rd_req = 1'b0; rd_addr = '0; sd_dout = '0; sd_ready = 1'b0;
        #3 rst_n = 1'b0;
        tick();
        tick();
        check("rst sd_we", 32'(sd_we), 32'd0);
        check("rst sd_rd", 32'(sd_rd), 32'd0);
        check("rst dl_wait", 32'(dl_wait), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst sd_addr", 32'(sd_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // single download write, sd_ready three cycles after sd_we
        base = n_wait;
        dl_wr = 1'b1; dl_addr = 25'h0; dl_data = 8'h5A;
        tick();
        dl_wr = 1'b0;
        check("wr sd_we", 32'(sd_we), 32'd1);
        check("wr sd_addr", 32'(sd_addr), 32'h0);
        check("wr sd_din", 32'(sd_din), 32'h5A);
        check("wr dl_wait", 32'(dl_wait), 32'd1);
        check("wr busy", 32'(busy), 32'd1);
        tick();
        check("wr sd_we pulse", 32'(sd_we), 32'd0);
        tick();
        tick();
        sd_ready = 1'b1;
        tick();
        sd_ready = 1'b0;
        check("wr dl_wait low", 32'(dl_wait), 32'd0);
        check("wr busy low", 32'(busy), 32'd0);
        check("wr dl_wait cycles", 32'(n_wait - base), 32'd4);

        do_read("rd100", 25'h100, 8'hC3, 25'h10D);
        do_read("rdwrap", 25'h1FFFFFF, 8'h77, 25'h000000C);

        // write and read requested in the same idle cycle, plus overrun during WRITE
        base = n_sd_we;
        dl_wr = 1'b1; dl_addr = 25'h20; dl_data = 8'h11;
        rd_req = 1'b1; rd_addr = 25'h40;
        tick();
        check("prio sd_we", 32'(sd_we), 32'd1);
        check("prio sd_rd", 32'(sd_rd), 32'd0);
        check("prio sd_addr", 32'(sd_addr), 32'h20);
        check("prio sd_din", 32'(sd_din), 32'h11);
        dl_addr = 25'h30; dl_data = 8'h22;
        tick();
        dl_wr = 1'b0;
        check("ovr err", 32'(err), 32'd2);
        sd_ready = 1'b1;
        tick();
        sd_ready = 1'b0;
        check("prio dl_wait low", 32'(dl_wait), 32'd0);
        check("prio no early rd", 32'(sd_rd), 32'd0);
        tick();
        check("prio sd_rd", 32'(sd_rd), 32'd1);
        check("prio rd sd_addr", 32'(sd_addr), 32'h4D);
        check("prio one write", 32'(n_sd_we - base), 32'd1);
        tick();
        sd_ready = 1'b1; sd_dout = 8'hA5;
        tick();
        sd_ready = 1'b0;
        check("prio rd_valid", 32'(rd_valid), 32'd1);
        check("prio rd_data", 32'(rd_data), 32'hA5);
        rd_req = 1'b0;
        tick();

        // sd_ready withheld on a read
        rd_req = 1'b1; rd_addr = 25'h200;
        tick();
        check("to sd_rd", 32'(sd_rd), 32'd1);
        rd_req = 1'b0;
        base = n_rd_valid;
        repeat (62) tick();
        check("to still waiting", 32'(busy), 32'd1);
        check("to err before", 32'(err), 32'd2);
        tick();
        check("to err set", 32'(err), 32'd3);
        check("to recover busy", 32'(busy), 32'd1);
        tick();
        check("to busy low", 32'(busy), 32'd0);
        check("to no rd_valid", 32'(n_rd_valid - base), 32'd0);
        dl_active = 1'b1;
        tick();
        check("err cleared", 32'(err), 32'd0);

        // reads ignored during download
        base = n_sd_rd;
        rd_req = 1'b1; rd_addr = 25'h100;
        repeat (4) tick();
        check("dl rd ignored", 32'(n_sd_rd - base), 32'd0);
        check("dl busy", 32'(busy), 32'd0);
        rd_req = 1'b0; dl_active = 1'b0;
        tick();

        // download starts while a read is in flight
        rd_req = 1'b1; rd_addr = 25'h300;
        tick();
        check("dlr sd_addr", 32'(sd_addr), 32'h30D);
        dl_active = 1'b1;
        tick();
        sd_ready = 1'b1; sd_dout = 8'h5C;
        tick();
        sd_ready = 1'b0;
        check("dlr rd_valid", 32'(rd_valid), 32'd1);
        check("dlr rd_data", 32'(rd_data), 32'h5C);
        rd_req = 1'b0;
        tick();
        dl_active = 1'b0;
        tick();

`ifdef GNW_ARB_RDCACHE_EN
        do_read("cmiss", 25'h100, 8'hC3, 25'h10D);
        base = n_sd_rd;
        rd_req = 1'b1; rd_addr = 25'h100;
        tick();
        check("chit rd_valid", 32'(rd_valid), 32'd1);
        check("chit rd_data", 32'(rd_data), 32'hC3);
        rd_req = 1'b0;
        tick();
        check("chit no sd_rd", 32'(n_sd_rd - base), 32'd0);
        dl_wr = 1'b1; dl_addr = 25'h10D; dl_data = 8'h44;
        tick();
        dl_wr = 1'b0;
        check("cinv sd_we", 32'(sd_we), 32'd1);
        tick();
        sd_ready = 1'b1;
        tick();
        sd_ready = 1'b0;
        tick();
        do_read("cinv", 25'h100, 8'h44, 25'h10D);
`else
        do_read("norpt1", 25'h100, 8'hC3, 25'h10D);
        do_read("norpt2", 25'h100, 8'h3C, 25'h10D);
`endif

        check("no we+rd overlap", 32'(n_both), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gnw_sdram_arb.md
# gnw_sdram_arb

SDRAM port arbiter for the Game & Watch core. It shares the single SDRAM controller port between the HPS download writer (ROM image, LCD background/segment artwork and config header) and the LCD compositor's byte-read port. It applies the 13-byte config-header offset to LCD reads and generates download backpressure (`ioctl_wait`). It replaces the direct address/enable muxing in the top level.

## Interface
Parameters:
- ADDR_W, 25, byte-address width on all ports
- HDR_BYTES, 13, offset added to every LCD read address (config header length)
- TIMEOUT, 63, max cycles waiting for `sd_ready` before abandoning an access (fits 6-bit counter)

Ports (name direction width meaning):
- clk  in  1  system clock (clk_sys, 100 MHz); the only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- dl_active  in  1  download in progress (ioctl_download)
- dl_wr  in  1  one-cycle write strobe (ioctl_wr)
- dl_addr  in  ADDR_W  raw download byte address
- dl_data  in  8  download byte
- dl_wait  out  1  backpressure to HPS; high while a write is pending or in flight
- rd_req  in  1  LCD read request, level, held until rd_valid
- rd_addr  in  ADDR_W  LCD read address, unshifted
- rd_data  out  8  read byte, valid with rd_valid
- rd_valid  out  1  one-cycle read-complete pulse
- sd_addr  out  ADDR_W  SDRAM address, stable from issue to sd_ready
- sd_din  out  8  SDRAM write data
- sd_we  out  1  one-cycle write command
- sd_rd  out  1  one-cycle read command
- sd_dout  in  8  SDRAM read data, valid with sd_ready
- sd_ready  in  1  one-cycle completion from controller
- busy  out  1  state != IDLE
- err  out  2  sticky: [0] timeout, [1] write overrun; cleared by reset or dl_active rising edge

Reset values: all outputs 0; state IDLE; pending flag, timeout counter, cache valid cleared.

## Operation
- States IDLE, WRITE, READ, RECOVER.
- dl_wr latches dl_addr/dl_data into a pending register. dl_wr while pending is already set or in WRITE: byte dropped, err[1] set.
- IDLE priority: pending write first. Otherwise rd_req and not dl_active starts a read. rd_req during dl_active is ignored; no rd_valid.
- Write: sd_addr = dl_addr raw, sd_we pulse, enter WRITE. On sd_ready: clear pending, go IDLE.
- Read: sd_addr = (rd_addr + HDR_BYTES) mod 2^ADDR_W, sd_rd pulse, enter READ. On sd_ready: register sd_dout into rd_data, pulse rd_valid, go IDLE.
- rd_req is not sampled in the cycle rd_valid is high. This prevents re-issue before the requester drops it.
- Timeout counter clears on entry to WRITE/READ and increments each waiting cycle. Reaching TIMEOUT: go RECOVER for one cycle, set err[0], drop pending or abandon the read (no rd_valid), then IDLE.
- dl_active rising during READ: the read completes normally. Later reads are blocked.
- A pending write arriving during READ waits; dl_wait stays high.

## Timing
- Write: dl_wr at cycle N; pending and dl_wait high at N+1; sd_we at N+1 when IDLE. sd_ready at M (M >= N+2). dl_wait low at M+1. Next dl_wr is accepted at M+1.
- Read: rd_req sampled at N; sd_rd at N+1; sd_ready at M; rd_valid/rd_data at M+1.
- sd_we and sd_rd are never high together; at most one command is outstanding.
- All outputs are registered.

## Configuration
- GNW_ARB_RDCACHE_EN defined: single-entry read cache holding the shifted-address tag, data and valid.
  - A hit in IDLE gives rd_valid at N+1 with no sd_rd.
  - A miss fills the cache on sd_ready.
  - Invalidate on a write whose address equals the tag, on dl_active rising, and on timeout.
- Undefined: every read goes to SDRAM. Cache logic is absent.

## Structure
- Package gnw_arb_pkg holds:
  - arb_state_t enum (IDLE, WRITE, READ, RECOVER)
  - HDR_BYTES default
  - ERR_TIMEOUT=0, ERR_OVERRUN=1 bit indices
- Sub-module gnw_arb_rdcache (tag/data/valid, lookup and invalidate) is instantiated only under GNW_ARB_RDCACHE_EN.

## Test plan
- dl_wr addr 0x0 data 0x5A, sd_ready 3 cycles after sd_we: expect sd_we=1 with sd_addr=0x0000000, sd_din=0x5A, dl_wait high for 4 cycles.
- dl_active=0, rd_req with rd_addr 0x100, sd_dout 0xC3: expect sd_rd with sd_addr 0x10D, then rd_valid with rd_data=0xC3 one cycle after sd_ready, and exactly one sd_rd.
- rd_addr 0x1FFFFFF: expect sd_addr 0x000000C (wrap-around).
- Pending write and rd_req in the same IDLE cycle: expect sd_we first, sd_rd only after the write's sd_ready; second dl_wr during WRITE sets err[1].
- sd_ready withheld: expect RECOVER after 63 waiting cycles, err[0]=1, no rd_valid, busy low next cycle; err clears on next dl_active rising.
- With GNW_ARB_RDCACHE_EN: repeat a read of 0x100 and expect rd_valid one cycle after rd_req with no sd_rd. A write to 0x10D then forces the next read of 0x100 to SDRAM.
